// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: instruction-cache address view, FSM states
// and geometry constants.
package cpu_types_pkg;

    localparam int ICACHE_SETS = 16;
    localparam int ICACHE_IDXW = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAGW = 32 - ICACHE_IDXW - 2;

    // Packed view of a fetch byte address for the default cache geometry
    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// Frame storage for the direct-mapped instruction cache: valid/tag/data per
// set, one asynchronous read port and one synchronous write port.
module icache_frames
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS,
    parameter int IDXW = $clog2(SETS),
    parameter int TAGW = 32 - IDXW - 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_valid,
    output logic [TAGW-1:0] rd_tag,
    output logic [31:0]     rd_data,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [TAGW-1:0] wr_tag,
    input  logic [31:0]     wr_data
);

    logic [SETS-1:0] valid_q, valid_d;
    logic [TAGW-1:0] tag_mem  [SETS];
    logic [31:0]     data_mem [SETS];

    // A fill marks its frame valid; everything else holds
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Valid bits are the only cache state cleared by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: tag/data arrays are not reset; the valid bits alone gate their use,
    // which keeps the arrays mappable onto plain RAM.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache. Hits return the word in the
// same cycle; a miss fetches one word from memory over iREN/iwait and then
// re-evaluates the request. Optional hit/miss counters are built when
// ICACHE_STATS_EN is defined.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int          SETS    = ICACHE_SETS,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 32 - IDXW - 2;

    icache_state_t   state_q, state_d;
    logic [29:0]     fetch_word_q, fetch_word_d;   // word address of the pending fill
    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    logic [31:0]     rd_data;
    logic            hit;
    logic            fill_en;
    logic            byte_offset_unused;

    // Byte offset is irrelevant for word fetches
    assign byte_offset_unused = ^imemaddr[1:0];

    icache_frames #(
        .SETS (SETS)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (imemaddr[IDXW+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_en),
        .wr_idx   (fetch_word_q[IDXW-1:0]),
        .wr_tag   (fetch_word_q[29:IDXW]),
        .wr_data  (iload)
    );

    assign hit = (state_q == IDLE) && imemREN && rd_valid
                 && (rd_tag == imemaddr[31:IDXW+2]);

    // Next state, fill control and bus outputs; all default to idle values
    always_comb begin
        state_d      = state_q;
        fetch_word_d = fetch_word_q;
        ihit         = 1'b0;
        imemload     = 32'h0;
        iREN         = 1'b0;
        iaddr        = 32'h0;
        fill_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    ihit     = 1'b1;
                    imemload = rd_data;
                end else if (imemREN) begin
                    fetch_word_d = imemaddr[31:2];
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                // Fill target stays fixed even if the datapath squashes
                iREN  = 1'b1;
                iaddr = {fetch_word_q, 2'b00};
                if (!iwait) begin
                    fill_en = !RST;   // a fill landing on reset is discarded
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            fetch_word_q <= PC_INIT[31:2];
        end else begin
            state_q      <= state_d;
            fetch_word_q <= fetch_word_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Count IDLE hit cycles and IDLE->FETCH transitions; both wrap naturally
    always_comb begin
        hit_count_d  = hit_count_q + 32'(ihit);
        miss_count_d = miss_count_q
                       + 32'((state_q == IDLE) && (state_d == FETCH));
    end

    // Counter registers, cleared by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
